// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Control FSM for a multi-cycle MIPS datapath that shares one memory port
// between instruction fetch and data access. Moore outputs are decoded from
// the current state. The one exception is FETCH, where IR/PC loads follow
// i_mem_ready. The FSM inserts wait states on the memory handshake, can give
// up on a stuck memory and go to HALT, and traps illegal opcodes into HALT.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_op[5:0]        opcode field IR[31:26]
//   i_zero           ALU zero flag (consumed by the datapath's PC gating)
//   i_mem_ready      memory completes its access this cycle
//   o_pc_write       unconditional PC load
//   o_pc_write_cond  PC load if zero
//   o_iord           memory address select: 0=PC, 1=ALUOut
//   o_mem_read       memory read strobe
//   o_mem_write      memory write strobe
//   o_ir_write       IR load
//   o_mem_to_reg     write-back select: 1=MDR
//   o_reg_dst        destination select: 1=rd, 0=rt
//   o_reg_write      register file write
//   o_alu_src_a      0=PC, 1=A
//   o_alu_src_b[1:0] 00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   o_alu_op[1:0]    00=add, 01=sub, 10=funct
//   o_pc_source[1:0] 00=ALU, 01=ALUOut, 10=jump target
//   o_state[3:0]     current state (debug)
//   o_halted         trap state reached
//   o_inst_count     retired-instruction counter
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,   // wait cycles before HALT, 0 = wait forever
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_op,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic             o_pc_write_cond,
    output logic             o_iord,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_mem_to_reg,
    output logic             o_reg_dst,
    output logic             o_reg_write,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic [1:0]       o_pc_source,
    output logic [3:0]       o_state,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_inst_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // The counter value seen during the last allowed wait cycle. The increment
    // on that edge would make the counter reach MEM_TIMEOUT, so the FSM leaves
    // for HALT on that same edge.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_inst_count;
    logic              w_is_wait;
    logic              w_timeout;
    logic              w_retire;

    // Raw strobes before reset gating.
    logic w_pc_write, w_pc_write_cond, w_mem_read, w_mem_write, w_ir_write, w_reg_write;

    // The zero flag qualifies o_pc_write_cond inside the datapath, so the
    // controller only carries it through the interface.
    logic w_unused_zero;
    assign w_unused_zero = i_zero;

    assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LAST);
    // Every instruction that completes returns to FETCH. A trap or a timeout
    // goes to HALT instead, so it never counts as retired.
    assign w_retire  = (r_state != S_FETCH) && (w_next == S_FETCH);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_FETCH;
            r_wait       <= '0;
            r_inst_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_is_wait && !i_mem_ready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_retire) begin
                r_inst_count <= r_inst_count + CNT_W'(1);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_next = S_HALT;
        unique case (r_state)
            S_FETCH: begin
                if (i_mem_ready)    w_next = S_DECODE;
                else if (w_timeout) w_next = S_HALT;
                else                w_next = S_FETCH;
            end
            S_DECODE: begin
                unique case (i_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEMADR: w_next = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (i_mem_ready)    w_next = S_MEMWB;
                else if (w_timeout) w_next = S_HALT;
                else                w_next = S_MEMRD;
            end
            S_MEMWR: begin
                if (i_mem_ready)    w_next = S_FETCH;
                else if (w_timeout) w_next = S_HALT;
                else                w_next = S_MEMWR;
            end
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_HALT;
        endcase
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        o_iord          = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_alu_op        = 2'b00;
        o_pc_source     = 2'b00;
        unique case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                o_alu_src_b = 2'b01;
                w_ir_write  = i_mem_ready;
                w_pc_write  = i_mem_ready;
            end
            S_DECODE: o_alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                o_iord      = 1'b1;
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                o_pc_source     = 2'b01;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                o_pc_source = 2'b10;
            end
            S_ADDIWB: w_reg_write = 1'b1;
            default: ;
        endcase
    end

    // Reset forces the state to FETCH, but FETCH itself drives a read. Gating
    // every strobe with i_rst_n drops them the instant reset asserts, so no
    // partial write can complete.
    assign o_pc_write      = w_pc_write      & i_rst_n;
    assign o_pc_write_cond = w_pc_write_cond & i_rst_n;
    assign o_mem_read      = w_mem_read      & i_rst_n;
    assign o_mem_write     = w_mem_write     & i_rst_n;
    assign o_ir_write      = w_ir_write      & i_rst_n;
    assign o_reg_write     = w_reg_write     & i_rst_n;

    assign o_state      = r_state;
    assign o_halted     = (r_state == S_HALT);
    assign o_inst_count = r_inst_count;

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle control FSM for the next-generation MIPS core. It replaces single-cycle decode with a shared-memory, multi-state datapath.
- Sequences PC, IR, ALU, register file and the single unified memory port through fetch/decode/execute/memory/writeback states.
- Inserts wait states on a memory-ready handshake and traps on illegal opcodes.
- Sits between the instruction register's opcode field and the datapath muxes and enables.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles on MemReady before entering HALT (0 = no timeout)
- CNT_W, 32, width of retired-instruction counter

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Op  input  6  opcode, IR[31:26]
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if Zero
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR load
- MemtoReg  output  1  write-back select: 1=MDR
- RegDst  output  1  destination select: 1=rd, 0=rt
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0=PC, 1=A
- ALUSrcB  output  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- ALUOp  output  2  00=add, 01=sub, 10=funct
- PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
- State  output  4  current state (debug)
- Halted  output  1  trap state reached
- InstCount  output  CNT_W  retired instructions

Behaviour:
- Reset low (async): State=FETCH(0), InstCount=0, wait counter=0. All strobes are forced 0 while Reset is low. Other outputs hold their FETCH values.
- Outputs are Moore, decoded from State. Exception: in FETCH, IRWrite and PCWrite = MemReady.
- States and encodings:
  - FETCH 0: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. Stay while !MemReady, else go to DECODE.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
    - 100011/101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX
    - anything else -> HALT
  - MEMADR 2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
  - MEMRD 3: MemRead, IorD=1. Wait on MemReady, then go to MEMWB.
  - MEMWB 4: RegWrite, MemtoReg=1, RegDst=0. Go to FETCH.
  - MEMWR 5: MemWrite, IorD=1. Wait on MemReady, then go to FETCH.
  - EXEC 6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - ALUWB 7: RegWrite, RegDst=1, MemtoReg=0. Go to FETCH.
  - BRANCH 8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. Go to FETCH.
  - JUMP 9: PCWrite, PCSource=10. Go to FETCH.
  - ADDIEX 10: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
  - ADDIWB 11: RegWrite, RegDst=0, MemtoReg=0. Go to FETCH.
  - HALT 15: all strobes 0, Halted=1. Exit only via Reset. Codes 12-14 are unused and go to HALT.
- Strobes not listed for a state are 0. Unlisted mux selects are don't-care but must be stable within a state.
- Wait states (FETCH/MEMRD/MEMWR):
  - Strobes are held steady while waiting.
  - The wait counter increments each cycle with MemReady=0 and clears on state exit.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with MemReady still 0, the FSM goes to HALT next cycle.
- InstCount increments by 1 on the clock edge leaving MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB. It wraps modulo 2^CNT_W and holds in HALT.
- Op is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- Reset asserted mid-instruction: State goes to FETCH immediately and strobes drop the same instant. No partial write completes after the reset edge.

Test Plan:
- R-type, MemReady tied 1: Op=000000 -> State sequence 0,1,6,7,0. RegWrite=1 only in state 7 with RegDst=1. InstCount 0->1.
- lw with 2-cycle memory: MemReady=0 for 2 cycles in FETCH and in MEMRD -> states 0,0,0,1,2,3,3,3,4. IRWrite pulses once, MemtoReg=1 in state 4.
- sw then beq: sw -> 0,1,2,5 with MemWrite=1, IorD=1. beq -> 0,1,8 with PCWriteCond=1, ALUOp=01. InstCount ends at 2.
- Illegal Op=111111 -> 0,1,15. Halted=1, no strobes for 20 cycles, InstCount frozen. Reset low then high -> State=0, Halted=0.
- Timeout, MEM_TIMEOUT=15: MemReady held 0 in FETCH -> HALT after 15 wait cycles. With MEM_TIMEOUT=0, the FSM stays in FETCH for 100 cycles.
- Async reset during MEMWR with MemWrite=1: Reset low between edges -> MemWrite drops to 0 without a clock edge, State=0, InstCount=0.
